// File: rtl/lcd_write_queue.sv
// HD44780-style write queue: buffers {regsel, byte} writes and drains them to the panel
// over an 8- or 4-bit bus with parametrised setup, enable-pulse and settle timing.

// Flushable FIFO. Latency: head visible the cycle after the write.
// Backpressure: a write while full is dropped and pulses overflow for one cycle.
module lcd_wq_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_vld,
    input  logic [W-1:0]             wr_dat,
    input  logic                     rd_rdy,
    input  logic                     flush,
    output logic [W-1:0]             rd_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          overflow_q;
    logic          wr_en;
    logic          rd_en;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign wr_en    = wr_vld && !full && !flush;
    assign rd_en    = rd_rdy && !empty;
    assign rd_dat   = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign overflow = overflow_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= wr_vld && full && !flush;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
                count_q <= count_q + CW'(wr_en) - CW'(rd_en);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_dat;
    end
endmodule

// LCD write engine. Latency: head popped one cycle after it is queued into an idle engine.
// Backpressure: none upstream beyond full/overflow; the panel side is purely timed.
module lcd_write_queue #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BUS_WIDTH  = 8,
    parameter int DEPTH      = 16,
    parameter int SETUP_CYC  = 6,
    parameter int EN_CYC     = 25,
    parameter int SHORT_WAIT = 2500,
    parameter int LONG_WAIT  = 100000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic [7:0]             din,
    input  logic                   regsel,
    input  logic                   flush,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy,
    output logic                   overflow,
    output logic                   lcd_regsel,
    output logic                   lcd_read,
    output logic                   lcd_enable,
    output logic [BUS_WIDTH-1:0]   lcd_data
);
    localparam int MAX_A     = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
    localparam int MAX_B     = (SHORT_WAIT > LONG_WAIT) ? SHORT_WAIT : LONG_WAIT;
    localparam int MAX_CYC   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W     = $clog2(MAX_CYC + 1);
    localparam int NIB_SHIFT = 8 - BUS_WIDTH;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ENABLE = 2'd2;
    localparam logic [1:0] S_WAIT   = 2'd3;

    if (BUS_WIDTH != 8 && BUS_WIDTH != 4) begin : g_bad_width
        $error("lcd_write_queue: BUS_WIDTH must be 8 or 4");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("lcd_write_queue: DEPTH must be a power of two >= 2");
    end
    if (SETUP_CYC < 1 || EN_CYC < 1 || SHORT_WAIT < 1 || LONG_WAIT < 1 || CLK_HZ < 1) begin : g_bad_timing
        $error("lcd_write_queue: timing parameters must be >= 1");
    end

    logic [1:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [7:0]           byte_q, byte_d;
    logic                 rs_q, rs_d;
    logic                 en_q, en_d;
    logic                 lo_nib_q, lo_nib_d;
    logic [BUS_WIDTH-1:0] data_q, data_d;
    logic                 pop;
    logic [8:0]           head;
    logic                 long_wait;
    logic [CNT_W-1:0]     wait_last;

    lcd_wq_fifo #(.W(9), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_vld   (push),
        .wr_dat   ({regsel, din}),
        .rd_rdy   (pop),
        .flush    (flush),
        .rd_dat   (head),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    // Clear (0x01) and return-home (0x02/0x03) need the long settle.
    assign long_wait = !rs_q && (byte_q[7:2] == 6'd0) && (byte_q[1:0] != 2'd0);
    assign wait_last = long_wait ? CNT_W'(LONG_WAIT - 1) : CNT_W'(SHORT_WAIT - 1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        byte_d   = byte_q;
        rs_d     = rs_q;
        en_d     = en_q;
        lo_nib_d = lo_nib_q;
        data_d   = data_q;
        pop      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    byte_d   = head[7:0];
                    rs_d     = head[8];
                    data_d   = BUS_WIDTH'(head[7:0] >> NIB_SHIFT);
                    lo_nib_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
                    cnt_d   = '0;
                    en_d    = 1'b1;
                    state_d = S_ENABLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ENABLE: begin
                if (cnt_q == CNT_W'(EN_CYC - 1)) begin
                    cnt_d = '0;
                    en_d  = 1'b0;
                    if (BUS_WIDTH == 4 && !lo_nib_q) begin
                        lo_nib_d = 1'b1;
                        data_d   = BUS_WIDTH'(byte_q);
                        state_d  = S_SETUP;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (cnt_q == wait_last) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            byte_q   <= '0;
            rs_q     <= 1'b0;
            en_q     <= 1'b0;
            lo_nib_q <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            byte_q   <= byte_d;
            rs_q     <= rs_d;
            en_q     <= en_d;
            lo_nib_q <= lo_nib_d;
            data_q   <= data_d;
        end
    end

    assign busy       = (state_q != S_IDLE) || !empty;
    assign lcd_regsel = rs_q;
    assign lcd_read   = 1'b0;
    assign lcd_enable = en_q;
    assign lcd_data   = data_q;
endmodule
